// File: rtl/battle_pkg.sv
// Shared types and helpers for the battle turn sequencer: state encoding,
// key codes, HP widths and the floor-at-zero subtract.
package battle_pkg;

  localparam int HP_P_W  = 7;
  localparam int HP_E_W  = 8;
  localparam int ARITH_W = 9;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_INIT    = 4'd1;
  localparam logic [3:0] ST_P_WAIT  = 4'd2;
  localparam logic [3:0] ST_P_HIT   = 4'd3;
  localparam logic [3:0] ST_CHECK_E = 4'd4;
  localparam logic [3:0] ST_E_DELAY = 4'd5;
  localparam logic [3:0] ST_E_HIT   = 4'd6;
  localparam logic [3:0] ST_CHECK_P = 4'd7;
  localparam logic [3:0] ST_WIN     = 4'd8;
  localparam logic [3:0] ST_LOSE    = 4'd9;

  typedef enum logic [3:0] {
    IDLE    = ST_IDLE,
    INIT    = ST_INIT,
    P_WAIT  = ST_P_WAIT,
    P_HIT   = ST_P_HIT,
    CHECK_E = ST_CHECK_E,
    E_DELAY = ST_E_DELAY,
    E_HIT   = ST_E_HIT,
    CHECK_P = ST_CHECK_P,
    WIN     = ST_WIN,
    LOSE    = ST_LOSE
  } battle_state_e;

  localparam logic [7:0] KEY_ATK1 = 8'd1;
  localparam logic [7:0] KEY_ATK2 = 8'd2;
  localparam logic [7:0] KEY_ATK3 = 8'd3;
  localparam logic [7:0] KEY_ATK4 = 8'd4;
  localparam logic [7:0] KEY_HEAL = 8'd5;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [ARITH_W-1:0] sat0(input logic [ARITH_W-1:0] a,
                                              input logic [ARITH_W-1:0] b);
    return (b >= a) ? '0 : a - b;
  endfunction

endpackage

// File: rtl/battle_lfsr.sv
// 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1) plus the 0..9 accuracy fold of its
// low nibble; one instance feeds both the player accuracy and enemy rolls.
module battle_lfsr
  import battle_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk_b,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] lfsr,
  output logic [3:0] acc
);

  always_ff @(posedge clk_b) begin
    if (rst) begin
      lfsr <= SEED;
    end else if (en) begin
      lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? LFSR_TAPS : 8'h00);
    end
  end

  assign acc = (lfsr[3:0] >= 4'd10) ? lfsr[3:0] - 4'd10 : lfsr[3:0];

endmodule

// File: rtl/battle_turn_controller.sv
// RPG battle turn sequencer: HP registers, alternating turns, enemy think delay
// and win/lose flags. Define BATTLE_HEAL_EN to allow one heal (key 5) per battle.
module battle_turn_controller
  import battle_pkg::*;
#(
  parameter logic [6:0]  PLAYER_HP_INIT = 7'd100,
  parameter logic [7:0]  BOSS_HP_INIT   = 8'd150,
  parameter logic [7:0]  ENEMY_HP_BASE  = 8'd50,
  parameter logic [7:0]  DMG_UNIT       = 8'd10,
  parameter logic [6:0]  ENEMY_DMG_UNIT = 7'd8,
  parameter logic [15:0] ENEMY_DELAY    = 16'd50,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
  input  logic              clk_b,
  input  logic              rst,
  input  logic              col_e,
  input  logic              boss,
  input  logic              key_valid,
  input  logic [7:0]        key_in,
  output logic [HP_P_W-1:0] HP_player,
  output logic [HP_E_W-1:0] HP_enemy,
  output logic [2:0]        p_attack,
  output logic [2:0]        e_attack,
  output logic              player_turn,
  output logic              in_battle,
  output logic              win,
  output logic              lose
);

  battle_state_e state;
  logic [7:0]         lfsr;
  logic [3:0]         acc;
  logic [2:0]         key_lvl;
  logic [15:0]        dly_cnt;
  logic               key_atk;
  logic               key_take;
  logic [1:0]         e_lvl;
  logic [7:0]         roll_hp;
  logic [ARITH_W-1:0] p_dmg;
  logic [ARITH_W-1:0] e_dmg;
  logic [ARITH_W-1:0] hp_e_sub;
  logic [ARITH_W-1:0] hp_p_sub;

  battle_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_b (clk_b),
    .rst   (rst),
    .en    (1'b1),
    .lfsr  (lfsr),
    .acc   (acc)
  );

  assign key_atk  = key_valid && (key_in >= KEY_ATK1) && (key_in <= KEY_ATK4);
  assign e_lvl    = (lfsr[5:4] == 2'd0) ? 2'd1 : lfsr[5:4];
  assign roll_hp  = ENEMY_HP_BASE + (lfsr % 8'd50);
  assign p_dmg    = {6'd0, key_lvl} * {1'b0, DMG_UNIT};
  assign e_dmg    = {7'd0, e_lvl} * {2'd0, ENEMY_DMG_UNIT};
  assign hp_e_sub = sat0({1'b0, HP_enemy}, p_dmg);
  assign hp_p_sub = sat0({2'd0, HP_player}, e_dmg);

`ifdef BATTLE_HEAL_EN
  logic               heal_used;
  logic [ARITH_W-1:0] hp_p_heal_raw;
  logic [ARITH_W-1:0] hp_p_heal;

  assign key_take      = key_atk || (key_valid && (key_in == KEY_HEAL) && !heal_used);
  assign hp_p_heal_raw = {2'd0, HP_player} + 9'd20;
  assign hp_p_heal     = (hp_p_heal_raw > {2'd0, PLAYER_HP_INIT}) ? {2'd0, PLAYER_HP_INIT}
                                                                 : hp_p_heal_raw;
`else
  assign key_take = key_atk;
`endif

  always_ff @(posedge clk_b) begin
    if (rst) begin
      state       <= IDLE;
      HP_player   <= PLAYER_HP_INIT;
      HP_enemy    <= '0;
      p_attack    <= '0;
      e_attack    <= '0;
      player_turn <= 1'b0;
      in_battle   <= 1'b0;
      win         <= 1'b0;
      lose        <= 1'b0;
      key_lvl     <= '0;
      dly_cnt     <= '0;
`ifdef BATTLE_HEAL_EN
      heal_used   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (col_e) begin
            state     <= INIT;
            in_battle <= 1'b1;
            win       <= 1'b0;
            lose      <= 1'b0;
          end
        end
        INIT: begin
          HP_player   <= PLAYER_HP_INIT;
          HP_enemy    <= boss ? BOSS_HP_INIT : roll_hp;
          p_attack    <= '0;
          e_attack    <= '0;
          player_turn <= 1'b1;
          state       <= P_WAIT;
`ifdef BATTLE_HEAL_EN
          heal_used   <= 1'b0;
`endif
        end
        P_WAIT: begin
          if (key_take) begin
            key_lvl     <= key_in[2:0];
            player_turn <= 1'b0;
            state       <= P_HIT;
          end
        end
        P_HIT: begin
`ifdef BATTLE_HEAL_EN
          if ({5'd0, key_lvl} == KEY_HEAL) begin
            HP_player <= hp_p_heal[HP_P_W-1:0];
            p_attack  <= key_lvl;
            heal_used <= 1'b1;
          end else
`endif
          if ({1'b0, key_lvl} <= acc) begin
            HP_enemy <= hp_e_sub[HP_E_W-1:0];
            p_attack <= key_lvl;
          end else begin
            p_attack <= '0;
          end
          state <= CHECK_E;
        end
        CHECK_E: begin
          if (HP_enemy == '0) begin
            win   <= 1'b1;
            state <= WIN;
          end else begin
            dly_cnt <= ENEMY_DELAY - 16'd1;
            state   <= E_DELAY;
          end
        end
        E_DELAY: begin
          if (dly_cnt == '0) begin
            state <= E_HIT;
          end else begin
            dly_cnt <= dly_cnt - 16'd1;
          end
        end
        E_HIT: begin
          if (acc == 4'd0) begin
            e_attack <= '0;
          end else begin
            HP_player <= hp_p_sub[HP_P_W-1:0];
            e_attack  <= {1'b0, e_lvl};
          end
          state <= CHECK_P;
        end
        CHECK_P: begin
          if (HP_player == '0) begin
            lose  <= 1'b1;
            state <= LOSE;
          end else begin
            player_turn <= 1'b1;
            state       <= P_WAIT;
          end
        end
        WIN, LOSE: begin
          // Outcome flags stay up through IDLE until the next battle starts.
          if (!col_e) begin
            in_battle <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
